// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared widths, instruction type codes and beat-count helper
package inst_queue_pkg;
  localparam int INST_LEN_DEF = 220;
  localparam int BEAT_LEN_DEF = 32;
  typedef enum logic [3:0] {
    COMPUTE     = 4'd0,
    LOAD_WEIGHT = 4'd1,
    LOAD_BIAS   = 4'd2,
    LOAD_DATA   = 4'd3,
    WRITE_DATA  = 4'd4
  } inst_type_e;
  function automatic int calc_beats(input int inst_len, input int beat_len);
    return (inst_len + beat_len - 1) / beat_len;
  endfunction
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: host beat port and controller instruction port
interface inst_queue_if #(parameter int INST_LEN = 220, parameter int BEAT_LEN = 32);
  logic                wr_valid;
  logic [BEAT_LEN-1:0] wr_data;
  logic                wr_ready;
  logic [INST_LEN-1:0] instruct;
  logic                inst_empty;
  logic                inst_req;
  modport master (output wr_valid, wr_data, inst_req, input wr_ready, instruct, inst_empty);
  modport slave  (input wr_valid, wr_data, inst_req, output wr_ready, instruct, inst_empty);
endinterface

// File: rtl/inst_queue_fifo.sv
// inst_fifo_fwft: RAM-backed queue whose registered read port doubles as the FWFT head
module inst_fifo_fwft #(
  parameter int WIDTH      = 220,
  parameter int DEPTH_LOG2 = 6,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic head_vld_q, load, ram_rd, byp, ram_wr;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  // head reloads whenever it is empty or being consumed; an empty RAM lets a commit go straight in
  assign load      = !head_vld_q || pop_i;
  assign ram_rd    = load && ram_cnt_q != '0;
  assign byp       = BYPASS && load && ram_cnt_q == '0 && wr_i;
  assign ram_wr    = wr_i && !byp;
  assign ram_cnt_d = ram_cnt_q + CW'(ram_wr) - CW'(ram_rd);
  assign count_o   = ram_cnt_q + CW'(head_vld_q);
  assign full_o    = count_o == CW'(DEPTH);
  assign empty_o   = !head_vld_q;
  assign rd_data_o = head_q;
  always_ff @(posedge clk)
    if (ram_wr) mem[wr_ptr_q] <= wr_data_i;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + DEPTH_LOG2'(ram_wr);
      rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(ram_rd);
      ram_cnt_q <= ram_cnt_d;
      if (load) head_vld_q <= ram_rd || byp;
    end
    if (rst) head_q <= '0;
    else if (!flush_i && ram_rd) head_q <= mem[rd_ptr_q];
    else if (!flush_i && byp) head_q <= wr_data_i;
  end
endmodule

// File: rtl/inst_queue.sv
// inst_queue: assembles host beats into instructions and queues them for the controller
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int INST_LEN   = INST_LEN_DEF,
  parameter int BEAT_LEN   = BEAT_LEN_DEF,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  inst_queue_if.slave         bus,
  output logic [DEPTH_LOG2:0] inst_count,
  output logic [31:0]         issued_cnt,
  output logic                err_underflow,
  output logic                err_partial
);
  localparam int BEATS = calc_beats(INST_LEN, BEAT_LEN);
  localparam int LAST  = INST_LEN - BEAT_LEN * (BEATS - 1);
  localparam int BW    = $clog2(BEATS);
  logic [BEATS-2:0][BEAT_LEN-1:0] stage_q;
  logic [BW-1:0] beat_q, beat_d;
  logic full, last, accept, commit, pop;
  assign last         = beat_q == BW'(BEATS - 1);
  assign bus.wr_ready = !rst && (!full || !last);
  assign accept       = bus.wr_valid && bus.wr_ready && !flush;
  assign commit       = accept && last;
  assign pop          = bus.inst_req && !bus.inst_empty && !flush;
  assign beat_d       = flush ? '0 : accept ? (last ? '0 : beat_q + BW'(1)) : beat_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q        <= '0;
      issued_cnt    <= '0;
      err_underflow <= 1'b0;
      err_partial   <= 1'b0;
    end else begin
      beat_q        <= beat_d;
      issued_cnt    <= issued_cnt + 32'(pop);
      err_underflow <= err_underflow | (bus.inst_req && bus.inst_empty);
      err_partial   <= err_partial | (flush && beat_q != '0);
    end
    if (accept && !last) stage_q[beat_q] <= bus.wr_data;
  end
  inst_fifo_fwft #(.WIDTH(INST_LEN), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_i      (commit),
    .wr_data_i ({bus.wr_data[LAST-1:0], stage_q}),
    .pop_i     (pop),
    .rd_data_o (bus.instruct),
    .empty_o   (bus.inst_empty),
    .full_o    (full),
    .count_o   (inst_count)
  );
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed self-checking bench for the instruction queue
module tb_inst_queue;
  import inst_queue_pkg::*;
  localparam int IL = INST_LEN_DEF;
  localparam int BL = BEAT_LEN_DEF;
  localparam int BEATS = calc_beats(IL, BL);
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [6:0] inst_count;
  logic [31:0] issued_cnt;
  logic err_underflow, err_partial;
  int checks = 0, errors = 0, exp_issued = 0;
  logic [IL-1:0] sb[$];
  inst_queue_if #(.INST_LEN(IL), .BEAT_LEN(BL)) bus();
  inst_queue #(.INST_LEN(IL), .BEAT_LEN(BL), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .inst_count(inst_count),
    .issued_cnt(issued_cnt), .err_underflow(err_underflow), .err_partial(err_partial)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [IL-1:0] mk(input inst_type_e t, input int idx);
    logic [IL-1:0] w = '0;
    logic [31:0] v = idx;
    w[3:0] = t;
    w[35:4] = v;
    w[100 +: 32] = ~v;
    w[IL-1 -: 8] = 8'hA5 ^ v[7:0];
    return w;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send_beat(input logic [BL-1:0] d);
    int n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    while (!bus.wr_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.wr_ready) chk("beat_ready", bus.wr_ready, 1'b1);
    else step();
    bus.wr_valid = 1'b0;
  endtask
  // the unused top bits of the final beat are driven to ones so ignoring them is exercised
  task automatic send_inst(input logic [IL-1:0] w);
    logic [BL*BEATS-1:0] p = {{(BL*BEATS-IL){1'b1}}, w};
    for (int k = 0; k < BEATS; k++) send_beat(p[k*BL +: BL]);
    sb.push_back(w);
  endtask
  task automatic wait_head;
    int n = 0;
    while (bus.inst_empty && n < 2) begin
      step();
      n++;
    end
    chk("head_wait", bus.inst_empty, 1'b0);
  endtask
  task automatic pop_check(input string tag);
    wait_head();
    chk(tag, bus.instruct, sb.pop_front());
    bus.inst_req = 1'b1;
    step();
    bus.inst_req = 1'b0;
    exp_issued++;
  endtask
  initial begin
    logic [IL-1:0] w;
    logic [BL*BEATS-1:0] p;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.inst_req = 1'b0;
    step();
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("rst_empty", bus.inst_empty, 1'b1);
    chk("rst_instruct", bus.instruct, '0);
    chk("rst_count", inst_count, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_errs", {err_underflow, err_partial}, 2'b00);
    chk("rst_ready", bus.wr_ready, 1'b1);
    send_inst(IL'(1));
    wait_head();
    chk("first_type", bus.instruct[3:0], 4'd1);
    chk("first_count", inst_count, 1);
    pop_check("first_word");
    chk("first_drained", bus.inst_empty, 1'b1);
    send_inst(mk(COMPUTE, 1));
    send_inst(mk(LOAD_BIAS, 2));
    send_inst(mk(LOAD_DATA, 3));
    for (int i = 0; i < 3; i++) begin
      pop_check("seq3");
      step();
    end
    chk("seq3_empty", bus.inst_empty, 1'b1);
    chk("seq3_issued", issued_cnt, exp_issued);
    for (int i = 0; i < 64; i++) send_inst(mk(inst_type_e'(i % 5), i));
    step();
    step();
    chk("full_count", inst_count, 64);
    chk("full_beat0_ready", bus.wr_ready, 1'b1);
    w = mk(WRITE_DATA, 64);
    p = {{(BL*BEATS-IL){1'b1}}, w};
    for (int k = 0; k < BEATS - 1; k++) send_beat(p[k*BL +: BL]);
    bus.wr_valid = 1'b1;
    bus.wr_data = p[(BEATS-1)*BL +: BL];
    chk("full_stall", bus.wr_ready, 1'b0);
    step();
    step();
    chk("full_stall_held", bus.wr_ready, 1'b0);
    chk("full_count_held", inst_count, 64);
    pop_check("full_pop");
    chk("full_unstall", bus.wr_ready, 1'b1);
    step();
    bus.wr_valid = 1'b0;
    sb.push_back(w);
    chk("full_refill", inst_count, 64);
    while (sb.size() > 0) pop_check("full_drain");
    chk("full_drained", bus.inst_empty, 1'b1);
    for (int i = 0; i < 70; i++) begin
      send_inst(mk(inst_type_e'(i % 5), i));
      if (i >= 3) pop_check("wrap");
    end
    while (sb.size() > 0) pop_check("wrap_tail");
    chk("wrap_empty", bus.inst_empty, 1'b1);
    chk("wrap_issued", issued_cnt, exp_issued);
    send_inst(mk(LOAD_WEIGHT, 200));
    wait_head();
    w = mk(LOAD_BIAS, 201);
    p = {{(BL*BEATS-IL){1'b1}}, w};
    for (int k = 0; k < BEATS - 1; k++) send_beat(p[k*BL +: BL]);
    chk("both_head", bus.instruct, sb.pop_front());
    bus.wr_valid = 1'b1;
    bus.wr_data = p[(BEATS-1)*BL +: BL];
    bus.inst_req = 1'b1;
    chk("both_ready", bus.wr_ready, 1'b1);
    step();
    bus.wr_valid = 1'b0;
    bus.inst_req = 1'b0;
    exp_issued++;
    sb.push_back(w);
    chk("both_count", inst_count, 1);
    pop_check("both_next");
    for (int i = 0; i < 4; i++) send_inst(mk(COMPUTE, 300 + i));
    wait_head();
    bus.inst_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_pop", bus.instruct, sb.pop_front());
      step();
    end
    bus.inst_req = 1'b0;
    exp_issued += 4;
    chk("hold_empty", bus.inst_empty, 1'b1);
    chk("hold_no_underflow", err_underflow, 1'b0);
    chk("hold_issued", issued_cnt, exp_issued);
    bus.inst_req = 1'b1;
    step();
    bus.inst_req = 1'b0;
    chk("underflow_flag", err_underflow, 1'b1);
    chk("underflow_count", inst_count, 0);
    chk("underflow_issued", issued_cnt, exp_issued);
    for (int k = 0; k < 3; k++) send_beat(32'hDEAD_0000 + k);
    chk("partial_clear", err_partial, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("partial_flag", err_partial, 1'b1);
    chk("partial_empty", bus.inst_empty, 1'b1);
    send_inst(mk(LOAD_DATA, 500));
    pop_check("after_partial");
    send_inst(mk(LOAD_WEIGHT, 600));
    send_inst(mk(LOAD_BIAS, 601));
    wait_head();
    flush = 1'b1;
    bus.inst_req = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = 32'hBAD0_BAD0;
    step();
    flush = 1'b0;
    bus.inst_req = 1'b0;
    bus.wr_valid = 1'b0;
    sb.delete();
    chk("flush_empty", bus.inst_empty, 1'b1);
    chk("flush_count", inst_count, 0);
    chk("flush_issued", issued_cnt, exp_issued);
    send_inst(mk(WRITE_DATA, 700));
    pop_check("after_flush");
    chk("final_issued", issued_cnt, exp_issued);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction source that sits directly upstream of the top-level controller (topcontrol).
- Accepts 32-bit host beats over a valid/ready port and assembles them into INST_LEN-bit instructions.
- Buffers assembled instructions in a circular first-word-fall-through (FWFT) queue.
- Presents the head instruction on `instruct` with `inst_empty`; pops on the controller's `inst_req` pulse.

Parameters:
- INST_LEN, 220, instruction width; must match the controller.
- BEAT_LEN, 32, host write beat width.
- DEPTH_LOG2, 6, log2 of queue depth (64 instructions).
- BEATS, ceil(INST_LEN/BEAT_LEN) = 7, derived localparam; beats per instruction.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of queue and beat assembler; does not clear counters.
- wr_valid  in  1  host beat valid.
- wr_data  in  BEAT_LEN  host beat; beat 0 carries instruction bits [31:0], beat k carries bits [32k+31:32k].
- wr_ready  out  1  beat accepted when wr_valid && wr_ready.
- instruct  out  INST_LEN  head instruction (FWFT).
- inst_empty  out  1  1 = no valid head.
- inst_req  in  1  pop strobe from the controller, one cycle per consumed instruction.
- inst_count  out  DEPTH_LOG2+1  instructions currently stored, including the head.
- issued_cnt  out  32  total pops since reset; wraps.
- err_underflow  out  1  sticky; set when a pop arrives while `inst_empty`=1.
- err_partial  out  1  sticky; set when `flush` arrives with a partially assembled instruction.

Behaviour:
- Reset values (rst=1 at posedge):
  - inst_empty=1, instruct=0, inst_count=0, issued_cnt=0.
  - err_underflow=0, err_partial=0, wr_ready=0 during reset, then 1.
  - Beat counter=0; read and write pointers=0.
  - Reset mid-assembly discards partial beats.
- Assembler:
  - Beat counter runs 0..BEATS-1.
  - An accepted beat k is written into staging bits [32k+31:32k].
  - The last beat uses only the low INST_LEN-32*(BEATS-1) = 28 bits; the upper 4 bits are ignored.
  - On the last beat, the staged word plus the current beat commits to the queue in the same cycle and the counter returns to 0.
- wr_ready:
  - wr_ready = !(queue full) || beat counter != BEATS-1.
  - Non-final beats are always accepted; only the committing beat stalls on full.
  - Full means count == 2^DEPTH_LOG2, counting the FWFT output register.
- Storage:
  - Inferred RAM with registered read, plus one output register forming the FWFT head.
  - Commit-to-visible latency when the queue is empty: `inst_empty` falls 2 cycles after the committing beat's edge (RAM write, then prefetch).
  - A commit into an empty queue may bypass the RAM directly into the output register (1-cycle latency). Either latency is legal; verification must not assume one or the other.
- Pop:
  - `inst_req` sampled high with `inst_empty`=0 advances the head.
  - From the next edge, `instruct` shows the next instruction, or `inst_empty`=1 if none remain.
  - This one-cycle turnaround is mandatory: the controller re-evaluates `instruct` 2 cycles after asserting `inst_req`.
  - A held `inst_req` pops once per cycle.
- Simultaneous commit and pop: both take effect; inst_count is unchanged. When the queue holds exactly 1 instruction, the new word becomes the head with no empty bubble if bypass is implemented; otherwise at most 1 empty cycle.
- Underflow: `inst_req` while `inst_empty`=1 → no pointer change, err_underflow=1 (sticky until rst).
- Pointers are DEPTH_LOG2 bits, wrap modulo depth; full/empty is decided by inst_count.
- flush:
  - Pointers, count and beat counter go to 0; inst_empty=1 next cycle.
  - A beat accepted in the flush cycle is dropped.
  - A pop in the flush cycle is ignored and does not count.
  - flush has priority over everything except rst.
- issued_cnt increments on every valid pop.

Decomposition:
- Shared package:
  - INST_LEN and BEAT_LEN defaults.
  - Instruction type codes: COMPUTE=0, LOAD_WEIGHT=1, LOAD_BIAS=2, LOAD_DATA=3, WRITE_DATA=4.
  - Localparam function for BEATS.
- Sub-module `inst_fifo_fwft`: width/depth-parameterised RAM, FWFT output register, pointers, count, optional bypass.
- The top level holds the assembler, error flags and issued_cnt.

Test Plan:
- Reset, then 7 beats with beat0=0x0000_0001 and the others 0 → inst_empty falls within 2 cycles of beat 7; instruct[3:0]=1; inst_count=1.
- Write 3 instructions (type 0, 2, 3); pulse inst_req one cycle at a time, 2 cycles apart → instruct[3:0] steps 0→2→3, then inst_empty=1; issued_cnt=3.
- Fill 64 instructions → wr_ready=0 only on the 7th beat of instruction 65; one pop → that beat accepted within 2 cycles; inst_count stays 64.
- Write 70 instructions through 64 depth with interleaved pops (pointer wrap) → all 70 are popped in order; instruct[35:4] carries the sequence index 0..69.
- Pop on empty → err_underflow=1, inst_count=0; send 3 beats then flush → err_partial=1, beat counter reset; the next 7 beats form a correct instruction.
- Hold inst_req for 4 cycles with 4 instructions queued → 4 pops on consecutive cycles, inst_empty=1 after the 4th, no underflow flag.
